ramp_pwm_sched: RTL
===================

RAMP_PWM_SCHED -- requirements
Module: ramp_pwm_sched

Interface
REQ-001 Parameter CLK_DIV, default 10000: clk cycles per PWM tick; legal range 2..65535.
REQ-002 Parameter PERIOD, default 100: ticks per PWM period; legal range 2..127.
REQ-003 clk  input  1  system clock (100 MHz); every register updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  duty command present.
REQ-006 cmd_ready  output  1  block can accept a command this cycle.
REQ-007 cmd_ch  input  2  target channel 0..3.
REQ-008 cmd_duty  input  7  requested on-time, in ticks.
REQ-009 cmd_step  input  4  ramp increment per period; 0 means an immediate jump.
REQ-010 pwm_out  output  4  per-channel PWM outputs.
REQ-011 busy  output  4  bit i high while channel i's current duty differs from its target.
REQ-012 period_start  output  1  one-cycle pulse at the start of each PWM period.

Function
REQ-013 Prescaler counter counts 0..CLK_DIV-1 and then wraps; tick is high in the cycle where the counter equals CLK_DIV-1.
REQ-014 Period counter pcount counts 0..PERIOD-1 and advances only on tick; a tick at PERIOD-1 wraps it to 0.
REQ-015 Boundary cycle = tick AND pcount==PERIOD-1.
REQ-016 period_start is registered and is high for exactly the one cycle after a boundary cycle, coincident with the first cycle of pcount==0.
REQ-017 Each channel i holds three registers: cur[i] (7b), tgt[i] (7b) and stp[i] (4b).
REQ-018 pwm_out[i] = (pcount < cur[i]): cur=0 gives constant low; cur>=PERIOD gives constant high.
REQ-019 Command handshake: a command is accepted on a cycle with cmd_valid AND cmd_ready.
REQ-020 An accepted command loads tgt[cmd_ch] = min(cmd_duty, PERIOD) and stp[cmd_ch] = cmd_step at that edge.
REQ-021 cmd_ready = NOT reset AND NOT boundary cycle; a command presented during a boundary cycle is not accepted and must be held by the source.
REQ-022 cur[i] changes only on a boundary-cycle edge, so a period never contains a partial duty change.
REQ-023 Boundary update when stp[i]==0: cur[i] <= tgt[i].
REQ-024 Boundary update when cur[i]<tgt[i]: cur[i] <= min(cur[i]+stp[i], tgt[i]).
REQ-025 Boundary update when cur[i]>tgt[i]: cur[i] <= max(cur[i]-stp[i], tgt[i]).
REQ-026 Boundary update when cur[i]==tgt[i]: cur[i] is unchanged.
REQ-027 Ramp arithmetic uses 8-bit intermediates, so there is no overflow or underflow; the result never passes tgt.
REQ-028 A new command to a channel that is mid-ramp retargets it from the present cur[i]; the ramp restarts from that value.
REQ-029 Channels are independent; commands to one channel never alter another channel's registers.
REQ-030 busy[i] = (cur[i] != tgt[i]), combinational from registered values.

Reset
REQ-031 While reset is high, the following all load 0 at each edge: the prescaler, pcount, and every cur, tgt and stp register.
REQ-032 While reset is high, period_start is 0 and cmd_ready is 0; pwm_out is therefore 0 and busy is 0.
REQ-033 Reset asserted mid-ramp or mid-period abandons all state; after release, counting restarts from prescaler=0, pcount=0.
REQ-034 cmd_ready is 1 in the first cycle after reset deasserts.

Verification (bench parameters: CLK_DIV=2, PERIOD=10)
REQ-035 Reset release -> pwm_out=0000, busy=0000, cmd_ready=1; period_start pulses every 20 clk.
REQ-036 Command ch0, duty=4, step=0 -> busy[0] high until the next boundary, then low; pwm_out[0] is high for 8 clk of every 20 clk.
REQ-037 Command ch1, duty=9, step=3, starting from cur=0 -> cur[1] goes 3, 6, 9 over three successive boundaries; busy[1] clears after the third.
REQ-038 Command ch2, duty=120 -> tgt=10, and pwm_out[2] is constant high after the next boundary; a following command of duty=0, step=4 ramps cur to 6, 2, 0.
REQ-039 cmd_valid held through a boundary cycle -> cmd_ready=0 for that cycle; the command is accepted on the next cycle; channel 3 is unaffected.
REQ-040 Reset pulsed during the REQ-037 ramp at cur=6 -> all outputs 0 on the following cycle; busy=0000; no residual ramp after release.

Source files
------------

// File: rtl/ramp_pwm_sched_if.sv
// Duty-command channel into the ramped PWM scheduler.
// Source owns valid/ch/duty/step; the scheduler owns ready.
interface ramp_pwm_sched_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_ch;
  logic [6:0] cmd_duty;
  logic [3:0] cmd_step;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_duty,
    output cmd_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_duty,
    input  cmd_step,
    output cmd_ready
  );
endinterface

// File: rtl/ramp_pwm_sched.sv
// Four-channel PWM generator whose duty ramps toward a commanded
// target by a fixed step once per period, only at period boundaries.
module ramp_pwm_sched #(
  parameter int CLK_DIV = 10000,
  parameter int PERIOD  = 100
) (
  input  logic             clk,
  input  logic             reset,
  ramp_pwm_sched_if.slave  cmd,
  output logic [3:0]       pwm_out,
  output logic [3:0]       busy,
  output logic             period_start
);

  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
  localparam logic [6:0]  P_MAX   = 7'(PERIOD - 1);
  localparam logic [6:0]  P_FULL  = 7'(PERIOD);

  logic [15:0] pre;
  logic [6:0]  pcount;
  logic        tick;
  logic        boundary;
  logic        accept;
  logic [6:0]  duty_clamp;

  logic [6:0] cur [4];
  logic [6:0] tgt [4];
  logic [3:0] stp [4];

  assign tick       = (pre == DIV_MAX);
  assign boundary   = tick && (pcount == P_MAX);
  assign cmd.cmd_ready = !reset && !boundary;
  assign accept     = cmd.cmd_valid && cmd.cmd_ready;
  assign duty_clamp = (cmd.cmd_duty > P_FULL) ? P_FULL
                                              : cmd.cmd_duty;

  // 8-bit intermediates keep up/down steps from wrapping past tgt
  function automatic logic [6:0] ramp(
    input logic [6:0] c,
    input logic [6:0] t,
    input logic [3:0] s
  );
    logic [7:0] c8, t8, s8, up, dn;
    c8 = {1'b0, c};
    t8 = {1'b0, t};
    s8 = {4'b0, s};
    up = c8 + s8;
    dn = c8 - s8;
    ramp = c;
    if (s == 4'd0)
      ramp = t;
    else if (c < t)
      ramp = (up >= t8) ? t : up[6:0];
    else if (c > t)
      ramp = (c8 <= t8 + s8) ? t : dn[6:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      pre          <= '0;
      pcount       <= '0;
      period_start <= 1'b0;
    end else begin
      pre          <= tick ? 16'd0 : pre + 16'd1;
      period_start <= boundary;
      if (tick)
        pcount <= (pcount == P_MAX) ? 7'd0 : pcount + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        cur[i] <= '0;
        tgt[i] <= '0;
        stp[i] <= '0;
      end else begin
        if (boundary)
          cur[i] <= ramp(cur[i], tgt[i], stp[i]);
        if (accept && cmd.cmd_ch == 2'(i)) begin
          tgt[i] <= duty_clamp;
          stp[i] <= cmd.cmd_step;
        end
      end
    end
  end

  always_comb begin
    pwm_out = '0;
    busy    = '0;
    for (int i = 0; i < 4; i++) begin
      pwm_out[i] = (pcount < cur[i]);
      busy[i]    = (cur[i] != tgt[i]);
    end
  end

endmodule
